esteira_planta: RTL and testbench
=================================

Name: esteira_planta

Overview:
- Responder (plant-side) block for the bottling-line process controller: consumes its commands (conveyor move, fill valve, capper/cork decrement, dozen increment).
- Returns the status signals that controller waits on: motor stopped at filling/QC/sealing stations, bottle full, cork available.
- Holds cork stock and bottle/dozen counters.
- Sits between the process FSM and the board I/O; also serves as a closed-loop plant model for simulation.

Parameters:
T_TRECHO, 8, clock cycles of motor-on needed to travel between adjacent stations (>=2)
T_ENCHER, 5, clock cycles of valve-open at filling station until bottle full (>=1)
ROLHA_W, 5, width of cork stock counter
ROLHAS_INI, 10, cork stock after reset
ROLHAS_MAX, 20, cork stock loaded by refill (< 2^ROLHA_W)
DUZIA_W, 4, width of dozen counter

Ports:
clk  in  1  clock, all state updates on rising edge
Reset  in  1  synchronous, active-low reset
Comando_Mover_Esteira  in  1  motor on while high
Valv_Enchimento  in  1  filling valve open
Dec_Rolha  in  1  one cork consumed per cycle high
Inc_Duzia  in  1  one sealed bottle counted per cycle high
Reposicao_Rolha  in  1  refill cork stock to ROLHAS_MAX
Motor_Parado_Pos_Enchimento  out  1  stopped at filling station
Motor_Parado_Pos_CQ  out  1  stopped at QC station
Motor_Parado_Pos_Lacre  out  1  stopped at sealing station
Sensor_Garrafa_Cheia  out  1  bottle at filler is full
Rolha_Disponivel  out  1  cork stock nonzero
Estoque_Rolhas  out  ROLHA_W  current cork stock
Contador_Garrafas  out  4  bottles in current dozen, 0..11
Contador_Duzias  out  DUZIA_W  completed dozens
Duzia_Completa  out  1  one-cycle pulse on dozen completion
Motor_Ligado  out  1  registered copy of motor activity (moving this cycle)

Behaviour:
Reset (Reset==0 at rising edge):
- pos=ENCH, em_estacao=1, trecho=0, nivel=0, stock=ROLHAS_INI.
- Garrafas=0, Duzias=0, Duzia_Completa=0, Motor_Ligado=0.
- Overrides all inputs, including mid-travel and mid-fill.

Position FSM:
- pos in {ENCH=0, CQ=1, LACRE=2}, ring ENCH->CQ->LACRE->ENCH. Plus em_estacao flag and trecho counter (0..T_TRECHO-1).
- em_estacao=1 & Comando=1: em_estacao<=0, trecho<=1 (this cycle counts as travel).
- em_estacao=0 & Comando=1:
  - if trecho==T_TRECHO-1: em_estacao<=1, pos<=next(pos), trecho<=0.
  - else: trecho++.
- em_estacao=0 & Comando=0: hold (paused between stations); no Motor_Parado asserted.
- Travel from station departure to next arrival = exactly T_TRECHO consecutive Comando-high cycles.
- Motor_Parado_Pos_X = em_estacao & (pos==X). Decoded from registers only; no combinational path from any input (the controller derives Comando from these).
- Arriving at a station while Comando is still high: flag high for exactly one cycle, then departs (discarded bottle passing the sealer).
- Motor_Ligado <= Comando.

Fill:
- nivel increments, saturating at T_ENCHER, when Valv_Enchimento=1 & em_estacao=1 & pos==ENCH.
- Valve ignored elsewhere.
- nivel<=0 on departure from ENCH.
- Sensor_Garrafa_Cheia = (nivel==T_ENCHER), register-decoded.

Corks:
- Reposicao_Rolha=1: stock<=ROLHAS_MAX (wins over Dec same cycle).
- Else Dec_Rolha=1 & stock>0: stock--.
- Dec at stock 0: no change, no wrap.
- Rolha_Disponivel = (stock!=0).

Counting (on Inc_Duzia=1):
- Garrafas<11: Garrafas++.
- Garrafas==11: Garrafas<=0, Duzias++ (wraps mod 2^DUZIA_W), Duzia_Completa<=1 next cycle.
- Duzia_Completa is 0 otherwise.

Test Plan:
- Reset release with all inputs 0 -> Motor_Parado_Pos_Enchimento=1, Estoque_Rolhas=10, Rolha_Disponivel=1, counters 0, other flags 0.
- Valv_Enchimento held 5 cycles at ENCH -> Sensor_Garrafa_Cheia rises after 5th edge; further valve cycles keep it 1; Comando high 1 cycle -> sensor 0 next cycle.
- Comando held high from ENCH -> Pos_CQ high exactly 8 edges later; drop Comando for 3 cycles at trecho=4 -> arrival delayed by 3 cycles.
- Comando held high continuously through CQ and LACRE -> each of Pos_CQ and Pos_Lacre pulses 1 cycle, 8 cycles apart; stops with Pos_Enchimento when Comando drops on arrival.
- Dec_Rolha 12 cycles from 10 -> stock 0 after 10, stays 0, Rolha_Disponivel=0; Reposicao_Rolha with Dec_Rolha same cycle -> stock 20.
- 12 Inc_Duzia pulses -> Garrafas 0..11 then 0, Duzias=1, one-cycle Duzia_Completa; Reset low mid-travel -> all reset values next edge.

Source files
------------

// File: rtl/esteira_planta.sv
// Plant-side responder for the bottling-line controller: conveyor position, filler level,
// cork stock and bottle/dozen counters. Also usable as a closed-loop plant model.
module esteira_planta #(
  parameter int unsigned T_TRECHO   = 8,
  parameter int unsigned T_ENCHER   = 5,
  parameter int unsigned ROLHA_W    = 5,
  parameter int unsigned ROLHAS_INI = 10,
  parameter int unsigned ROLHAS_MAX = 20,
  parameter int unsigned DUZIA_W    = 4
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               Comando_Mover_Esteira,
  input  logic               Valv_Enchimento,
  input  logic               Dec_Rolha,
  input  logic               Inc_Duzia,
  input  logic               Reposicao_Rolha,
  output logic               Motor_Parado_Pos_Enchimento,
  output logic               Motor_Parado_Pos_CQ,
  output logic               Motor_Parado_Pos_Lacre,
  output logic               Sensor_Garrafa_Cheia,
  output logic               Rolha_Disponivel,
  output logic [ROLHA_W-1:0] Estoque_Rolhas,
  output logic [3:0]         Contador_Garrafas,
  output logic [DUZIA_W-1:0] Contador_Duzias,
  output logic               Duzia_Completa,
  output logic               Motor_Ligado
);

  localparam int unsigned TW = (T_TRECHO > 2) ? $clog2(T_TRECHO) : 1;
  localparam int unsigned NW = $clog2(T_ENCHER + 1);

  localparam logic [TW-1:0]      TRECHO_ULT  = TW'(T_TRECHO - 1);
  localparam logic [NW-1:0]      NIVEL_CHEIO = NW'(T_ENCHER);
  localparam logic [ROLHA_W-1:0] STOCK_INI   = ROLHA_W'(ROLHAS_INI);
  localparam logic [ROLHA_W-1:0] STOCK_MAX   = ROLHA_W'(ROLHAS_MAX);

  localparam logic [1:0] POS_ENCH  = 2'd0;
  localparam logic [1:0] POS_CQ    = 2'd1;
  localparam logic [1:0] POS_LACRE = 2'd2;

  logic [1:0]         pos_q, pos_d, pos_prox;
  logic               em_estacao_q, em_estacao_d;
  logic [TW-1:0]      trecho_q, trecho_d;
  logic [NW-1:0]      nivel_q, nivel_d;
  logic [ROLHA_W-1:0] stock_q, stock_d;
  logic [3:0]         garrafas_q, garrafas_d;
  logic [DUZIA_W-1:0] duzias_q, duzias_d;
  logic               duzia_completa_q, duzia_completa_d;
  logic               motor_ligado_q;

  always_comb begin
    unique case (pos_q)
      POS_ENCH:  pos_prox = POS_CQ;
      POS_CQ:    pos_prox = POS_LACRE;
      default:   pos_prox = POS_ENCH;
    endcase
  end

  // Conveyor travel and filler level. The departure cycle already counts as travel,
  // and leaving the filler empties the level so the next bottle starts dry.
  always_comb begin
    pos_d        = pos_q;
    em_estacao_d = em_estacao_q;
    trecho_d     = trecho_q;
    nivel_d      = nivel_q;
    if (Comando_Mover_Esteira) begin
      if (em_estacao_q) begin
        em_estacao_d = 1'b0;
        trecho_d     = TW'(1);
        if (pos_q == POS_ENCH) begin
          nivel_d = '0;
        end
      end else if (trecho_q == TRECHO_ULT) begin
        em_estacao_d = 1'b1;
        trecho_d     = '0;
        pos_d        = pos_prox;
      end else begin
        trecho_d = trecho_q + TW'(1);
      end
    end else if (Valv_Enchimento && em_estacao_q && (pos_q == POS_ENCH) &&
                 (nivel_q != NIVEL_CHEIO)) begin
      nivel_d = nivel_q + NW'(1);
    end
  end

  always_comb begin
    stock_d = stock_q;
    if (Reposicao_Rolha) begin
      stock_d = STOCK_MAX;
    end else if (Dec_Rolha && (stock_q != '0)) begin
      stock_d = stock_q - ROLHA_W'(1);
    end
  end

  always_comb begin
    garrafas_d       = garrafas_q;
    duzias_d         = duzias_q;
    duzia_completa_d = 1'b0;
    if (Inc_Duzia) begin
      if (garrafas_q == 4'd11) begin
        garrafas_d       = '0;
        duzias_d         = duzias_q + DUZIA_W'(1);
        duzia_completa_d = 1'b1;
      end else begin
        garrafas_d = garrafas_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      pos_q            <= POS_ENCH;
      em_estacao_q     <= 1'b1;
      trecho_q         <= '0;
      nivel_q          <= '0;
      stock_q          <= STOCK_INI;
      garrafas_q       <= '0;
      duzias_q         <= '0;
      duzia_completa_q <= 1'b0;
      motor_ligado_q   <= 1'b0;
    end else begin
      pos_q            <= pos_d;
      em_estacao_q     <= em_estacao_d;
      trecho_q         <= trecho_d;
      nivel_q          <= nivel_d;
      stock_q          <= stock_d;
      garrafas_q       <= garrafas_d;
      duzias_q         <= duzias_d;
      duzia_completa_q <= duzia_completa_d;
      motor_ligado_q   <= Comando_Mover_Esteira;
    end
  end

  // Status is decoded from registers only: the controller derives its motor command from it.
  assign Motor_Parado_Pos_Enchimento = em_estacao_q && (pos_q == POS_ENCH);
  assign Motor_Parado_Pos_CQ         = em_estacao_q && (pos_q == POS_CQ);
  assign Motor_Parado_Pos_Lacre      = em_estacao_q && (pos_q == POS_LACRE);
  assign Sensor_Garrafa_Cheia        = (nivel_q == NIVEL_CHEIO);
  assign Rolha_Disponivel            = (stock_q != '0);
  assign Estoque_Rolhas              = stock_q;
  assign Contador_Garrafas           = garrafas_q;
  assign Contador_Duzias             = duzias_q;
  assign Duzia_Completa              = duzia_completa_q;
  assign Motor_Ligado                = motor_ligado_q;

endmodule

// File: tb/tb_esteira_planta.sv
// Self-checking bench for esteira_planta: directed scenarios plus randomized traffic
// against a distance/stock/count reference model.
module tb_esteira_planta;

  localparam int T_TRECHO   = 8;
  localparam int T_ENCHER   = 5;
  localparam int ROLHAS_INI = 10;
  localparam int ROLHAS_MAX = 20;

  logic       clk = 1'b0;
  logic       Reset = 1'b0;
  logic       cmd = 1'b0, valve = 1'b0, dec = 1'b0, inc = 1'b0, refill = 1'b0;
  logic       p_ench, p_cq, p_lacre, cheia, disp, dc, mot;
  logic [4:0] estoque;
  logic [3:0] garrafas;
  logic [3:0] duzias;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: station index, distance travelled, fill level, stock, counts.
  int m_pos, m_dist, m_niv, m_stock, m_gar, m_duz;
  bit m_em, m_dc, m_mot;

  esteira_planta dut (
    .clk                         (clk),
    .Reset                       (Reset),
    .Comando_Mover_Esteira       (cmd),
    .Valv_Enchimento             (valve),
    .Dec_Rolha                   (dec),
    .Inc_Duzia                   (inc),
    .Reposicao_Rolha             (refill),
    .Motor_Parado_Pos_Enchimento (p_ench),
    .Motor_Parado_Pos_CQ         (p_cq),
    .Motor_Parado_Pos_Lacre      (p_lacre),
    .Sensor_Garrafa_Cheia        (cheia),
    .Rolha_Disponivel            (disp),
    .Estoque_Rolhas              (estoque),
    .Contador_Garrafas           (garrafas),
    .Contador_Duzias             (duzias),
    .Duzia_Completa              (dc),
    .Motor_Ligado                (mot)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    if (!Reset) begin
      m_pos = 0; m_em = 1; m_dist = 0; m_niv = 0; m_stock = ROLHAS_INI;
      m_gar = 0; m_duz = 0; m_dc = 0; m_mot = 0;
      return;
    end
    m_mot = cmd;
    if (!cmd && valve && m_em && m_pos == 0 && m_niv < T_ENCHER) m_niv++;
    if (cmd) begin
      if (m_em) begin
        if (m_pos == 0) m_niv = 0;
        m_em = 0;
        m_dist = 1;
      end else if (m_dist + 1 == T_TRECHO) begin
        m_em = 1;
        m_dist = 0;
        m_pos = (m_pos + 1) % 3;
      end else begin
        m_dist++;
      end
    end
    if (refill) m_stock = ROLHAS_MAX;
    else if (dec && m_stock > 0) m_stock--;
    m_dc = 0;
    if (inc) begin
      if (m_gar < 11) m_gar++;
      else begin
        m_gar = 0;
        m_duz = (m_duz + 1) % 16;
        m_dc = 1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd = 0; valve = 0; dec = 0; inc = 0; refill = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 0;
    cycle();
    Reset = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 0;
    cycle();
    cycle();
    Reset = 1;
    cycle();
    n_vec++;
    if ({p_ench, p_cq, p_lacre, cheia, disp, dc, mot} !== 7'b1000100) begin
      n_err++;
      $display("FAIL reset_flags got=%b want=1000100",
               {p_ench, p_cq, p_lacre, cheia, disp, dc, mot});
    end
    n_vec++;
    if (estoque !== 5'd10 || garrafas !== 4'd0 || duzias !== 4'd0) begin
      n_err++;
      $display("FAIL reset_counts got stock=%0d gar=%0d duz=%0d want 10/0/0",
               estoque, garrafas, duzias);
    end
  endtask

  task automatic test_fill();
    do_reset();
    valve = 1;
    for (int i = 1; i <= 7; i++) begin
      cycle();
      n_vec++;
      if (cheia !== (i >= 5)) begin
        n_err++;
        $display("FAIL fill_level cyc=%0d got=%b want=%b", i, cheia, (i >= 5));
      end
    end
    valve = 0;
    cmd = 1;
    cycle();
    cmd = 0;
    n_vec++;
    if (cheia !== 1'b0 || mot !== 1'b1 || p_ench !== 1'b0) begin
      n_err++;
      $display("FAIL fill_depart got cheia=%b mot=%b ench=%b want 0/1/0", cheia, mot, p_ench);
    end
    // Valve is ignored while travelling
    valve = 1;
    cycle();
    valve = 0;
    n_vec++;
    if (cheia !== 1'b0 || mot !== 1'b0) begin
      n_err++;
      $display("FAIL fill_offstation got cheia=%b mot=%b want 0/0", cheia, mot);
    end
  endtask

  task automatic test_travel();
    do_reset();
    cmd = 1;
    for (int i = 1; i <= T_TRECHO; i++) begin
      cycle();
      n_vec++;
      if (p_cq !== (i == T_TRECHO) || p_ench !== 1'b0 || p_lacre !== 1'b0) begin
        n_err++;
        $display("FAIL travel_arrive cyc=%0d got cq=%b ench=%b lacre=%b want cq=%b",
                 i, p_cq, p_ench, p_lacre, (i == T_TRECHO));
      end
    end
    do_reset();
    cmd = 1;
    for (int i = 0; i < 4; i++) cycle();
    cmd = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_vec++;
      if ({p_ench, p_cq, p_lacre, mot} !== 4'b0000) begin
        n_err++;
        $display("FAIL travel_pause got=%b want=0000", {p_ench, p_cq, p_lacre, mot});
      end
    end
    cmd = 1;
    for (int i = 1; i <= 4; i++) begin
      cycle();
      n_vec++;
      if (p_cq !== (i == 4)) begin
        n_err++;
        $display("FAIL travel_resume cyc=%0d got=%b want=%b", i, p_cq, (i == 4));
      end
    end
    cmd = 0;
  endtask

  task automatic test_continuous();
    do_reset();
    cmd = 1;
    for (int i = 1; i <= 3 * T_TRECHO; i++) begin
      if (i == 3 * T_TRECHO) begin
        cycle();
        cmd = 0;
      end else begin
        cycle();
      end
      n_vec++;
      if (p_cq !== (i == T_TRECHO) || p_lacre !== (i == 2 * T_TRECHO) ||
          p_ench !== (i == 3 * T_TRECHO)) begin
        n_err++;
        $display("FAIL ring_pulse cyc=%0d got ench=%b cq=%b lacre=%b", i, p_ench, p_cq,
                 p_lacre);
      end
    end
    cycle();
    n_vec++;
    if (p_ench !== 1'b1 || mot !== 1'b0) begin
      n_err++;
      $display("FAIL ring_stop got ench=%b mot=%b want 1/0", p_ench, mot);
    end
  endtask

  task automatic test_corks();
    do_reset();
    dec = 1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      n_vec++;
      if (estoque !== 5'((i < 10) ? 10 - i : 0) || disp !== (i < 10)) begin
        n_err++;
        $display("FAIL cork_dec cyc=%0d got stock=%0d disp=%b want %0d/%b", i, estoque, disp,
                 (i < 10) ? 10 - i : 0, (i < 10));
      end
    end
    refill = 1;
    cycle();
    refill = 0;
    dec = 0;
    n_vec++;
    if (estoque !== 5'd20 || disp !== 1'b1) begin
      n_err++;
      $display("FAIL cork_refill got stock=%0d disp=%b want 20/1", estoque, disp);
    end
  endtask

  task automatic test_count();
    do_reset();
    inc = 1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      n_vec++;
      if (garrafas !== 4'(i % 12) || dc !== (i == 12) || duzias !== 4'(i / 12)) begin
        n_err++;
        $display("FAIL count cyc=%0d got gar=%0d dc=%b duz=%0d want %0d/%b/%0d", i, garrafas,
                 dc, duzias, i % 12, (i == 12), i / 12);
      end
    end
    inc = 0;
    cycle();
    n_vec++;
    if (dc !== 1'b0 || duzias !== 4'd1) begin
      n_err++;
      $display("FAIL count_pulse got dc=%b duz=%0d want 0/1", dc, duzias);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cmd = 1; dec = 1; inc = 1;
    for (int i = 0; i < 3; i++) cycle();
    Reset = 0;
    cycle();
    n_vec++;
    if ({p_ench, p_cq, p_lacre, cheia, dc, mot} !== 6'b100000 || estoque !== 5'd10 ||
        garrafas !== 4'd0 || duzias !== 4'd0) begin
      n_err++;
      $display("FAIL reset_mid got flags=%b stock=%0d gar=%0d duz=%0d",
               {p_ench, p_cq, p_lacre, cheia, dc, mot}, estoque, garrafas, duzias);
    end
    Reset = 1;
    idle_inputs();
    cycle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cmd    = ($urandom_range(0, 3) != 0);
      valve  = $urandom_range(0, 1);
      dec    = ($urandom_range(0, 3) == 0);
      refill = ($urandom_range(0, 31) == 0);
      inc    = $urandom_range(0, 1);
      Reset  = ($urandom_range(0, 63) != 0);
      cycle();
      n_vec++;
      if (p_ench !== (m_em && m_pos == 0) || p_cq !== (m_em && m_pos == 1) ||
          p_lacre !== (m_em && m_pos == 2) || cheia !== (m_niv == T_ENCHER) ||
          disp !== (m_stock != 0) || estoque !== 5'(m_stock) || garrafas !== 4'(m_gar) ||
          duzias !== 4'(m_duz) || dc !== m_dc || mot !== m_mot) begin
        n_err++;
        $display("FAIL random cyc=%0d got p=%b%b%b ch=%b st=%0d g=%0d d=%0d dc=%b m=%b want p=%b%b%b ch=%b st=%0d g=%0d d=%0d dc=%b m=%b",
                 i, p_ench, p_cq, p_lacre, cheia, estoque, garrafas, duzias, dc, mot,
                 (m_em && m_pos == 0), (m_em && m_pos == 1), (m_em && m_pos == 2),
                 (m_niv == T_ENCHER), m_stock, m_gar, m_duz, m_dc, m_mot);
      end
    end
    Reset = 1;
    idle_inputs();
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_travel();
    test_continuous();
    test_corks();
    test_count();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
